// File: rtl/mlp_seq_ctrl_if.sv
// mlp_seq_ctrl_if: bus bundle between the MLP sequencer and its image buffer / weight memory / host side
//   start_i        begin inference (sampled in IDLE only)
//   img_addr_o     pixel index to the image buffer; img_data_i returns that pixel in the same cycle
//   layer_sel_o    0 idle, 1 layer 1, 2 layer 2 (to the weight memory controller)
//   row_idx_o      current weight row (to the weight memory controller)
//   w1/b1/w2/b2    packed signed int8 weights and biases, lane j at [j*8 +: 8]
//   busy_o/done_o  inference in progress / one-cycle result-valid pulse
//   pred_o         argmax class; logits_packed_o final logits, lane k at [k*ACC_W +: ACC_W]
interface mlp_seq_ctrl_if #(
    parameter int N_HID = 32,
    parameter int N_OUT = 10,
    parameter int ACC_W = 32
);
    logic                     start_i;
    logic [9:0]               img_addr_o;
    logic [7:0]               img_data_i;
    logic [1:0]               layer_sel_o;
    logic [9:0]               row_idx_o;
    logic [N_HID*8-1:0]       w1_in_packed_i;
    logic [N_HID*8-1:0]       b1_in_packed_i;
    logic [N_OUT*8-1:0]       w2_in_packed_i;
    logic [N_OUT*8-1:0]       b2_in_packed_i;
    logic                     busy_o;
    logic                     done_o;
    logic [3:0]               pred_o;
    logic [N_OUT*ACC_W-1:0]   logits_packed_o;
    modport slave (
        input  start_i, img_data_i, w1_in_packed_i, b1_in_packed_i, w2_in_packed_i, b2_in_packed_i,
        output img_addr_o, layer_sel_o, row_idx_o, busy_o, done_o, pred_o, logits_packed_o
    );
    modport master (
        output start_i, img_data_i, w1_in_packed_i, b1_in_packed_i, w2_in_packed_i, b2_in_packed_i,
        input  img_addr_o, layer_sel_o, row_idx_o, busy_o, done_o, pred_o, logits_packed_o
    );
endinterface

// File: rtl/mlp_seq_ctrl.sv
// mlp_seq_ctrl: 784-32-10 int8 MLP inference sequencer (layer 1, layer 2, serial argmax)
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a run immediately
//   bus    mlp_seq_ctrl_if.slave: start, image buffer, weight memory, status and results
module mlp_seq_ctrl #(
    parameter int N_IN     = 784,
    parameter int N_HID    = 32,
    parameter int N_OUT    = 10,
    parameter int ACC_W    = 32,
    parameter int L1_SHIFT = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    mlp_seq_ctrl_if.slave bus
);
    localparam int HW = $clog2(N_HID);
    localparam logic [9:0] L1_LAST = 10'(N_IN - 1);
    localparam logic [9:0] L2_LAST = 10'(N_HID - 1);
    localparam logic [9:0] AM_LAST = 10'(N_OUT);

    typedef enum logic [2:0] {IDLE, L1, L1_BIAS, L2, L2_BIAS, ARGMAX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [9:0]              r_q, r_d;
    logic signed [ACC_W-1:0] acc1_q [N_HID];
    logic signed [ACC_W-1:0] acc2_q [N_OUT];
    logic signed [7:0]       h_q [N_HID];
    logic signed [ACC_W-1:0] logit_q [N_OUT];
    logic signed [ACC_W-1:0] best_val_q;
    logic [3:0]              best_idx_q, pred_q;

    logic signed [15:0]      p1 [N_HID];
    logic signed [ACC_W-1:0] s1 [N_HID];
    logic signed [ACC_W-1:0] sh1 [N_HID];
    logic signed [7:0]       h_d [N_HID];
    logic signed [15:0]      p2 [N_OUT];
    logic signed [7:0]       h_sel;
    logic [3:0]              am_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            IDLE:    if (bus.start_i) begin state_d = L1; r_d = '0; end
            L1:      if (r_q == L1_LAST) begin state_d = L1_BIAS; r_d = '0; end else r_d = r_q + 10'd1;
            L1_BIAS: state_d = L2;
            L2:      if (r_q == L2_LAST) begin state_d = L2_BIAS; r_d = '0; end else r_d = r_q + 10'd1;
            L2_BIAS: state_d = ARGMAX;
            ARGMAX:  if (r_q == AM_LAST) begin state_d = DONE; r_d = '0; end else r_d = r_q + 10'd1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Layer-1 MAC terms and the biased, shifted, clamped hidden activations
    always_comb begin
        for (int j = 0; j < N_HID; j++) begin
            p1[j]  = $signed(bus.img_data_i) * $signed(bus.w1_in_packed_i[j*8 +: 8]);
            s1[j]  = acc1_q[j] + {{(ACC_W-8){bus.b1_in_packed_i[j*8+7]}}, bus.b1_in_packed_i[j*8 +: 8]};
            sh1[j] = s1[j] >>> L1_SHIFT;
            h_d[j] = (sh1[j] < 0) ? 8'sd0 : (sh1[j] > 127) ? 8'sd127 : sh1[j][7:0];
        end
    end

    assign h_sel  = h_q[r_q[HW-1:0]];
    // Argmax step 0 seeds the running best; steps 1..N_OUT compare logit[step-1]
    assign am_idx = (r_q == 10'd0) ? 4'd0 : 4'(r_q - 10'd1);

    always_comb begin
        for (int k = 0; k < N_OUT; k++)
            p2[k] = h_sel * $signed(bus.w2_in_packed_i[k*8 +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_HID; j++) begin
                acc1_q[j] <= '0;
                h_q[j]    <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                acc2_q[k]  <= '0;
                logit_q[k] <= '0;
            end
            best_val_q <= '0;
            best_idx_q <= '0;
            pred_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    for (int j = 0; j < N_HID; j++) acc1_q[j] <= '0;
                    for (int k = 0; k < N_OUT; k++) acc2_q[k] <= '0;
                end
                L1: for (int j = 0; j < N_HID; j++)
                    acc1_q[j] <= acc1_q[j] + {{(ACC_W-16){p1[j][15]}}, p1[j]};
                L1_BIAS: for (int j = 0; j < N_HID; j++) h_q[j] <= h_d[j];
                L2: for (int k = 0; k < N_OUT; k++)
                    acc2_q[k] <= acc2_q[k] + {{(ACC_W-16){p2[k][15]}}, p2[k]};
                L2_BIAS: for (int k = 0; k < N_OUT; k++)
                    logit_q[k] <= acc2_q[k] + {{(ACC_W-8){bus.b2_in_packed_i[k*8+7]}}, bus.b2_in_packed_i[k*8 +: 8]};
                ARGMAX: if (r_q == 10'd0) begin
                    // Most-negative sentinel; strict compare keeps the lowest index on ties
                    best_val_q <= {1'b1, {(ACC_W-1){1'b0}}};
                    best_idx_q <= '0;
                end else if (logit_q[am_idx] > best_val_q) begin
                    best_val_q <= logit_q[am_idx];
                    best_idx_q <= am_idx;
                end
                DONE: pred_q <= best_idx_q;
                default: ;
            endcase
        end
    end

    assign bus.layer_sel_o = (state_q == L1 || state_q == L1_BIAS) ? 2'd1 :
                             (state_q == L2 || state_q == L2_BIAS) ? 2'd2 : 2'd0;
    assign bus.row_idx_o   = (state_q == L1 || state_q == L2) ? r_q : 10'd0;
    assign bus.img_addr_o  = (state_q == L1) ? r_q : 10'd0;
    assign bus.busy_o      = state_q != IDLE;
    assign bus.done_o      = state_q == DONE;
    assign bus.pred_o      = (state_q == DONE) ? best_idx_q : pred_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_logit
        assign bus.logits_packed_o[k*ACC_W +: ACC_W] = logit_q[k];
    end
endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// tb_mlp_seq_ctrl: directed self-checking bench for mlp_seq_ctrl with a reference-model scoreboard
module tb_mlp_seq_ctrl;
    localparam int N_IN  = 784;
    localparam int N_HID = 32;
    localparam int N_OUT = 10;
    localparam int ACC_W = 32;
    localparam int LAT   = N_IN + N_HID + N_OUT + 4;
    localparam int LW    = N_OUT * ACC_W;

    typedef struct {
        logic [3:0]    pred;
        logic [LW-1:0] logits;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_seq_ctrl_if bus();
    mlp_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic signed [7:0] pix [N_IN];
    logic signed [7:0] w1 [N_IN][N_HID];
    logic signed [7:0] b1 [N_HID];
    logic signed [7:0] w2 [N_HID][N_OUT];
    logic signed [7:0] b2 [N_OUT];

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndone = 0;
    int nruns = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done_o === 1'b1) ndone <= ndone + 1;

    // Image buffer and weight memory behaviour: combinational reads addressed by the DUT
    always_comb begin
        bus.img_data_i = pix[bus.img_addr_o];
        for (int j = 0; j < N_HID; j++) begin
            bus.w1_in_packed_i[j*8 +: 8] = w1[bus.row_idx_o][j];
            bus.b1_in_packed_i[j*8 +: 8] = b1[j];
        end
        for (int k = 0; k < N_OUT; k++) begin
            bus.w2_in_packed_i[k*8 +: 8] = w2[bus.row_idx_o[4:0]][k];
            bus.b2_in_packed_i[k*8 +: 8] = b2[k];
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int acc;
        int best;
        int hh [N_HID];
        for (int j = 0; j < N_HID; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) acc += int'(pix[i]) * int'(w1[i][j]);
            acc = (acc + int'(b1[j])) >>> 7;
            hh[j] = (acc < 0) ? 0 : (acc > 127) ? 127 : acc;
        end
        e.pred = 4'd0;
        e.logits = '0;
        best = 0;
        for (int k = 0; k < N_OUT; k++) begin
            acc = 0;
            for (int r = 0; r < N_HID; r++) acc += hh[r] * int'(w2[r][k]);
            acc += int'(b2[k]);
            e.logits[k*ACC_W +: ACC_W] = acc;
            if (k == 0 || acc > best) begin
                best = acc;
                e.pred = 4'(k);
            end
        end
        return e;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < N_IN; i++) begin
            pix[i] = 0;
            for (int j = 0; j < N_HID; j++) w1[i][j] = 0;
        end
        for (int j = 0; j < N_HID; j++) begin
            b1[j] = 0;
            for (int k = 0; k < N_OUT; k++) w2[j][k] = 0;
        end
        for (int k = 0; k < N_OUT; k++) b2[k] = 0;
    endtask

    // One inference: push expectation, pulse start, watch until done, pop and compare
    task automatic run(input bit steps, input bit extra, input bit hold);
        exp_t e;
        int t0;
        int n;
        bit seen;
        sb.push_back(model());
        nruns++;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        seen = 1'b0;
        while (!seen && cyc - t0 < LAT + 50) begin
            n = cyc - t0;
            bus.start_i = extra && (n == 100 || n == LAT - 1);
            if (steps && n >= 1 && n <= N_IN)
                check("l1_step", {bus.layer_sel_o, bus.row_idx_o, bus.img_addr_o}, {2'd1, 10'(n-1), 10'(n-1)});
            if (steps && n >= N_IN + 2 && n <= N_IN + N_HID + 1)
                check("l2_step", {bus.layer_sel_o, bus.row_idx_o, bus.img_addr_o}, {2'd2, 10'(n-N_IN-2), 10'd0});
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
                check("latency", LW'(n), LW'(LAT));
                check("busy_at_done", LW'(bus.busy_o), LW'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pred", LW'(bus.pred_o), LW'(e.pred));
                    check("logits", bus.logits_packed_o, e.logits);
                end else check("sb_empty", LW'(sb.size()), LW'(1));
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.start_i = 1'b0;
        check("done_seen", LW'(seen), LW'(1));
        if (hold) begin
            @(posedge clk); #1;
            check("idle_after", {bus.done_o, bus.busy_o, bus.layer_sel_o}, '0);
            check("pred_hold", LW'(bus.pred_o), LW'(e.pred));
        end
    endtask

    initial begin
        logic [LW-1:0] bvec;
        int k;
        bus.start_i = 1'b0;
        clear_all();
        #1;
        check("rst_out", {bus.busy_o, bus.done_o, bus.pred_o, bus.layer_sel_o, bus.row_idx_o, bus.img_addr_o}, '0);
        check("rst_logits", bus.logits_packed_o, '0);
        #3 rst_n = 1'b1;

        // All zero: latency, single done, per-cycle row/addr sequencing
        run(1'b1, 1'b0, 1'b1);
        check("zero_pred", LW'(bus.pred_o), LW'(0));

        // Bias-only logits and low-index tie break
        b2[7] = 5;
        run(1'b0, 1'b0, 1'b1);
        check("b2_pred7", LW'(bus.pred_o), LW'(7));
        b2[2] = 9;
        b2[6] = 9;
        run(1'b0, 1'b0, 1'b1);
        check("tie_pred2", LW'(bus.pred_o), LW'(2));

        // Saturating hidden layer
        clear_all();
        for (int i = 0; i < N_IN; i++) begin
            pix[i] = 127;
            for (int j = 0; j < N_HID; j++) w1[i][j] = 127;
        end
        for (int r = 0; r < N_HID; r++) w2[r][3] = 1;
        run(1'b0, 1'b0, 1'b1);
        check("logit3", LW'(bus.logits_packed_o[3*ACC_W +: ACC_W]), LW'(4064));
        check("sat_pred3", LW'(bus.pred_o), LW'(3));

        // Negative hidden sums clamp to zero, logits equal biases
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_HID; j++) w1[i][j] = -127;
        for (int j = 0; j < N_HID; j++) b1[j] = -128;
        for (k = 0; k < N_OUT; k++) b2[k] = 8'(k * 7 - 30);
        b2[4] = 60;
        bvec = '0;
        for (k = 0; k < N_OUT; k++) bvec[k*ACC_W +: ACC_W] = ACC_W'(int'(b2[k]));
        run(1'b0, 1'b0, 1'b1);
        check("neg_logits", bus.logits_packed_o, bvec);
        check("neg_pred4", LW'(bus.pred_o), LW'(4));

        // Mid-range random data, with ignored starts while busy and a back-to-back restart
        for (int i = 0; i < N_IN; i++) begin
            pix[i] = 8'($urandom_range(0, 255));
            for (int j = 0; j < N_HID; j++) w1[i][j] = 8'($urandom_range(0, 8)) - 8'sd4;
        end
        for (int j = 0; j < N_HID; j++) begin
            b1[j] = 8'($urandom_range(0, 255));
            for (k = 0; k < N_OUT; k++) w2[j][k] = 8'($urandom_range(0, 255));
        end
        for (k = 0; k < N_OUT; k++) b2[k] = 8'($urandom_range(0, 255));
        run(1'b0, 1'b1, 1'b0);
        run(1'b1, 1'b0, 1'b1);

        // Reset in the middle of layer 1 aborts at once; a fresh start reproduces the result
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        k = 0;
        while (bus.row_idx_o != 10'd300 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_row300", LW'(bus.row_idx_o), LW'(300));
        rst_n = 1'b0;
        #1;
        check("abort_out", {bus.busy_o, bus.done_o, bus.layer_sel_o, bus.row_idx_o, bus.img_addr_o}, '0);
        check("abort_res", {bus.pred_o, bus.logits_packed_o}, '0);
        #2 rst_n = 1'b1;
        run(1'b1, 1'b0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("done_count", LW'(ndone), LW'(nruns));
        check("sb_drained", LW'(sb.size()), LW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
